// File: rtl/outerprod_acc_pkg.sv
// Shared constants for the outer-product accumulator: state encoding,
// stream-window length and defaults common with the unary array.
package outerprod_acc_pkg;

    localparam int ROWNUM_DEF      = 4;
    localparam int COLNUM_DEF      = 4;
    localparam int BITWIDTH_DEF    = 8;
    localparam int OUTBITWIDTH_DEF = 9;
    localparam int ACCWIDTH_DEF    = 16;
    localparam int KDEPTH_DEF      = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_RUN  = 3'd2,
        ST_ACC  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // One unary stream window covers the full magnitude range.
    function automatic int stream_len(input int bitwidth);
        return 1 << (bitwidth - 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/outerprod_acc_cell.sv
// One tile entry: sign-magnitude product to two's complement, accumulate.
// Saturating update when OUTERPROD_ACC_SAT_EN is defined, otherwise wraps.
module outerprod_acc_cell
    import outerprod_acc_pkg::*;
#(
    parameter int OUTBITWIDTH = OUTBITWIDTH_DEF,
    parameter int ACCWIDTH    = ACCWIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   load_i,
    input  logic [OUTBITWIDTH-1:0] prod_i,
    output logic [ACCWIDTH-1:0]    acc_o
);

    localparam int MW = OUTBITWIDTH - 1;
    // One guard bit above the wider operand so the sum never wraps.
    localparam int EW = max2(ACCWIDTH, OUTBITWIDTH) + 1;

    logic [ACCWIDTH-1:0] acc_q, acc_d;
    logic [EW-1:0]       acc_x;
    logic [EW-1:0]       mag_x;
    logic [EW-1:0]       add_x;
    logic [EW-1:0]       sum_x;
    logic [ACCWIDTH-1:0] res;

    always_comb begin
        acc_x = {{(EW-ACCWIDTH){acc_q[ACCWIDTH-1]}}, acc_q};
        mag_x = {{(EW-MW){1'b0}}, prod_i[MW-1:0]};
        add_x = prod_i[MW] ? (~mag_x + EW'(1)) : mag_x;
        sum_x = acc_x + add_x;
    end

`ifdef OUTERPROD_ACC_SAT_EN
    logic [EW-ACCWIDTH:0] top_bits;
    logic                 ovf;

    always_comb begin
        top_bits = sum_x[EW-1:ACCWIDTH-1];
        ovf      = !((&top_bits) || (~|top_bits));
        if (!ovf) begin
            res = sum_x[ACCWIDTH-1:0];
        end else if (sum_x[EW-1]) begin
            res = {1'b1, {(ACCWIDTH-1){1'b0}}};
        end else begin
            res = {1'b0, {(ACCWIDTH-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^sum_x[EW-1:ACCWIDTH];
    assign res       = sum_x[ACCWIDTH-1:0];
`endif

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = res;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/outerprod_acc.sv
// Controller and accumulator bank for the unary outer-product array.
// Optional saturating accumulation: define OUTERPROD_ACC_SAT_EN.
module outerprod_acc
    import outerprod_acc_pkg::*;
#(
    parameter int ROWNUM      = ROWNUM_DEF,
    parameter int COLNUM      = COLNUM_DEF,
    parameter int BITWIDTH    = BITWIDTH_DEF,
    parameter int OUTBITWIDTH = OUTBITWIDTH_DEF,
    parameter int ACCWIDTH    = ACCWIDTH_DEF,
    parameter int KDEPTH      = KDEPTH_DEF
) (
    input  logic                                 iClk,
    input  logic                                 iRstN,
    input  logic                                 iVecValid,
    output logic                                 oVecReady,
    output logic                                 oPeEn,
    output logic                                 oPeClr,
    input  logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] iPeData,
    output logic                                 oValid,
    input  logic                                 iReady,
    output logic [ROWNUM*COLNUM*ACCWIDTH-1:0]    oData,
    output logic                                 oBusy
);

    localparam int NENT      = ROWNUM * COLNUM;
    localparam int STREAMLEN = stream_len(BITWIDTH);
    localparam int CW        = $clog2(STREAMLEN + 1);
    localparam int KW        = $clog2(KDEPTH + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] kcnt_q, kcnt_d;
    logic          acc_load;
    logic          acc_clr;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            kcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kcnt_q  <= kcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kcnt_d  = kcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (iVecValid) begin
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == CW'(STREAMLEN - 1)) begin
                    state_d = ST_ACC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ACC: begin
                kcnt_d = kcnt_q + KW'(1);
                if (kcnt_q == KW'(KDEPTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (iReady) begin
                    kcnt_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        oPeClr    = 1'b0;
        oPeEn     = 1'b0;
        oVecReady = 1'b0;
        oValid    = 1'b0;
        acc_load  = 1'b0;
        acc_clr   = 1'b0;
        oBusy     = (state_q != ST_IDLE);
        unique case (state_q)
            ST_CLR:  oPeClr = 1'b1;
            ST_RUN:  oPeEn  = 1'b1;
            ST_ACC: begin
                oVecReady = 1'b1;
                acc_load  = 1'b1;
            end
            ST_DONE: begin
                oValid  = 1'b1;
                acc_clr = iReady;
            end
            default: ;
        endcase
    end

    for (genvar e = 0; e < NENT; e++) begin : g_cell
        outerprod_acc_cell #(
            .OUTBITWIDTH(OUTBITWIDTH),
            .ACCWIDTH   (ACCWIDTH)
        ) u_cell (
            .clk_i (iClk),
            .rst_ni(iRstN),
            .clr_i (acc_clr),
            .load_i(acc_load),
            .prod_i(iPeData[e*OUTBITWIDTH +: OUTBITWIDTH]),
            .acc_o (oData[e*ACCWIDTH +: ACCWIDTH])
        );
    end

endmodule

// File: tb/tb_outerprod_acc.sv
// Scoreboard bench for outerprod_acc (KDEPTH=2), plus an 8-bit
// accumulator instance for the wrap/saturation boundary.
module tb_outerprod_acc;

    localparam int N   = 16;
    localparam int OBW = 9;
    localparam int AW  = 16;
    localparam int AW8 = 8;
    localparam int KD  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             vv, rdy, vr, en, clr, valid, busy;
    logic [N*OBW-1:0] pe;
    logic [N*AW-1:0]  data;

    logic             vv8, rdy8, vr8, en8, clr8, valid8, busy8;
    logic [N*OBW-1:0] pe8;
    logic [N*AW8-1:0] data8;

    outerprod_acc #(
        .ROWNUM(4), .COLNUM(4), .BITWIDTH(8),
        .OUTBITWIDTH(OBW), .ACCWIDTH(AW), .KDEPTH(KD)
    ) dut (
        .iClk(clk), .iRstN(rst_n), .iVecValid(vv), .oVecReady(vr),
        .oPeEn(en), .oPeClr(clr), .iPeData(pe), .oValid(valid),
        .iReady(rdy), .oData(data), .oBusy(busy)
    );

    outerprod_acc #(
        .ROWNUM(4), .COLNUM(4), .BITWIDTH(8),
        .OUTBITWIDTH(OBW), .ACCWIDTH(AW8), .KDEPTH(KD)
    ) dut8 (
        .iClk(clk), .iRstN(rst_n), .iVecValid(vv8), .oVecReady(vr8),
        .oPeEn(en8), .oPeClr(clr8), .iPeData(pe8), .oValid(valid8),
        .iReady(rdy8), .oData(data8), .oBusy(busy8)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [N*AW-1:0] expq[$];
    logic [N*AW-1:0] mon_exp;
    int en_cnt = 0;
    int vr_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return vr;
            1: return valid;
            2: return en;
            3: return vr8;
            4: return valid8;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_hi(input string name, input int w);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(w) && n < 1000);
        if (!sig(w)) begin
            total++;
            bad++;
            $display("FAIL %s: timeout after %0d cycles", name, n);
        end
    endtask

    function automatic logic [N*OBW-1:0] fill(input logic [OBW-1:0] v);
        logic [N*OBW-1:0] r;
        for (int e = 0; e < N; e++) r[e*OBW +: OBW] = v;
        return r;
    endfunction

    function automatic logic [N*AW-1:0] filla(input logic [AW-1:0] v);
        logic [N*AW-1:0] r;
        for (int e = 0; e < N; e++) r[e*AW +: AW] = v;
        return r;
    endfunction

    // Issue one KDEPTH=2 tile; expected tile goes to the scoreboard.
    task automatic do_tile(input logic [N*OBW-1:0] p0,
                           input logic [N*OBW-1:0] p1,
                           input logic [N*AW-1:0] exp);
        int c0;
        expq.push_back(exp);
        pe = p0;
        vv = 1'b1;
        c0 = cyc;
        wait_hi("vecready0", 0);
        @(posedge clk); #1;
        pe = p1;
        wait_hi("vecready1", 0);
        @(posedge clk); #1;
        vv = 1'b0;
        wait_hi("valid", 1);
        check("valid_latency", 64'(cyc - c0), 64'd262);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            en_cnt = 0;
            vr_cnt = 0;
        end else begin
            if (en) en_cnt++;
            if (vr) begin
                check("pe_en_len", 64'(en_cnt), 64'd128);
                en_cnt = 0;
                vr_cnt++;
            end
            if (valid && rdy) begin
                if (expq.size() == 0) begin
                    check("unexpected_tile", 64'd1, 64'd0);
                end else begin
                    mon_exp = expq.pop_front();
                    for (int e = 0; e < N; e++)
                        check($sformatf("tile_e%0d", e),
                              64'(data[e*AW +: AW]),
                              64'(mon_exp[e*AW +: AW]));
                end
                check("vecready_pulses", 64'(vr_cnt), 64'(KD));
                vr_cnt = 0;
            end
        end
    end

    logic [N*OBW-1:0] p0, p1;
    logic [N*AW-1:0]  ex;
    logic [AW8-1:0]   ex8;

    initial begin
        vv = 0; rdy = 1; pe = '0;
        vv8 = 0; rdy8 = 1; pe8 = '0;

        // reset state
        @(negedge clk);
        check("rst_en", 64'(en), 64'd0);
        check("rst_clr", 64'(clr), 64'd0);
        check("rst_vr", 64'(vr), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", 64'(|data), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
        end

        // all entries +64 twice
        do_tile(fill(9'd64), fill(9'd64), filla(16'd128));
        wait_hi("idle1", 5);

        // sign handling and entry ordering
        for (int e = 0; e < N; e++) begin
            p0[e*OBW +: OBW] = OBW'(e);
            p1[e*OBW +: OBW] = OBW'(e);
            ex[e*AW +: AW]   = AW'(2 * e);
        end
        p0[0 +: OBW]   = 9'h10A;
        p1[0 +: OBW]   = 9'h003;
        ex[0 +: AW]    = 16'hFFF9;
        p0[OBW +: OBW] = 9'h100;
        p1[OBW +: OBW] = 9'h100;
        ex[AW +: AW]   = 16'h0000;
        do_tile(p0, p1, ex);
        wait_hi("idle2", 5);

        // backpressure in DONE
        for (int e = 0; e < N; e++) begin
            p0[e*OBW +: OBW] = OBW'(e + 1);
            p1[e*OBW +: OBW] = OBW'(2 * e);
            ex[e*AW +: AW]   = AW'(3 * e + 1);
        end
        rdy = 1'b0;
        do_tile(p0, p1, ex);
        vv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(valid), 64'd1);
            check("bp_data", 64'(data == ex), 64'd1);
            check("bp_en", 64'(en), 64'd0);
            check("bp_clr", 64'(clr), 64'd0);
            check("bp_vr", 64'(vr), 64'd0);
        end
        @(posedge clk); #1;
        vv = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_xfer_valid", 64'(valid), 64'd0);
        check("post_xfer_acc", 64'(|data), 64'd0);
        wait_hi("idle3", 5);

        // reset at RUN cycle 50 of the second pair
        pe = fill(9'd64);
        vv = 1'b1;
        wait_hi("mr_vr0", 0);
        @(posedge clk); #1;
        wait_hi("mr_en", 2);
        repeat (50) @(posedge clk);
        #1;
        check("pre_rst_en", 64'(en), 64'd1);
        rst_n = 1'b0;
        vv = 1'b0;
        #1;
        check("mr_en_low", 64'(en), 64'd0);
        check("mr_acc_zero", 64'(|data), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_tile(fill(9'd64), fill(9'd64), filla(16'd128));
        wait_hi("idle4", 5);

        // 8-bit accumulator: 100 + 100
`ifdef OUTERPROD_ACC_SAT_EN
        ex8 = 8'h7F;
`else
        ex8 = 8'hC8;
`endif
        pe8 = fill(9'd100);
        vv8 = 1'b1;
        wait_hi("ovf_vr0", 3);
        @(posedge clk); #1;
        wait_hi("ovf_vr1", 3);
        @(posedge clk); #1;
        vv8 = 1'b0;
        wait_hi("ovf_valid", 4);
        for (int e = 0; e < N; e++)
            check($sformatf("ovf_e%0d", e),
                  64'(data8[e*AW8 +: AW8]), 64'(ex8));

        repeat (3) @(negedge clk);
        check("scoreboard_drain", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/outerprod_acc.md
# outerprod_acc

Downstream controller and accumulator for the unary outer-product array. It sequences the array's enable and clear for one full bitstream window per input vector pair, then reads the sign-magnitude partial products. Each product is converted to two's complement and summed over KDEPTH vector pairs in binary accumulators. The finished ROWNUM×COLNUM tile is presented on a valid/ready output handshake.

## Interface
- ROWNUM, 4, rows of the outer-product array
- COLNUM, 4, columns of the outer-product array
- BITWIDTH, 8, sign-magnitude input width of the array; stream window STREAMLEN = 2^(BITWIDTH-1) cycles
- OUTBITWIDTH, 9, array output width per entry: MSB sign, OUTBITWIDTH-1 magnitude bits
- ACCWIDTH, 16, two's-complement accumulator width per entry
- KDEPTH, 8, vector pairs accumulated per output tile (≥1)

Ports:
- iClk  in  1  clock, rising edge
- iRstN  in  1  asynchronous active-low reset
- iVecValid  in  1  upstream holds a vector pair stable on the array inputs
- oVecReady  out  1  one-cycle pulse: current vector pair consumed
- oPeEn  out  1  enable to array
- oPeClr  out  1  clear to array
- iPeData  in  ROWNUM*COLNUM*OUTBITWIDTH  array output, entry e at [(e+1)*OUTBITWIDTH-1 : e*OUTBITWIDTH], e = i*COLNUM+j
- oValid  out  1  result tile valid
- iReady  in  1  downstream accepts tile
- oData  out  ROWNUM*COLNUM*ACCWIDTH  accumulated tile, same entry ordering
- oBusy  out  1  high in any state except IDLE

## Operation
- States: IDLE, CLR, RUN, ACC, DONE.
- IDLE: oPeEn = 0 and oPeClr = 0. If iVecValid is high → CLR.
- CLR: oPeClr = 1 for one cycle → RUN. The cycle counter loads 0.
- RUN: oPeEn = 1 for exactly STREAMLEN cycles, counted 0..STREAMLEN-1. After the last count → ACC.
- ACC: for every entry, acc += (sign ? -mag : mag), sign-extended to ACCWIDTH. oVecReady = 1 this cycle only. kcnt increments.
  - If kcnt was KDEPTH-1 → DONE.
  - Otherwise → IDLE.
- DONE: oValid = 1 and oData = acc. When iReady is high: all acc clear to 0, kcnt clears to 0, → IDLE.
- A magnitude of 0 with sign 1 contributes 0.
- iVecValid is ignored outside IDLE. Upstream must hold the array inputs from IDLE acceptance until the oVecReady pulse.

## Timing
- Reset values: state = IDLE, kcnt = 0, cycle counter = 0, all acc = 0. Outputs oPeEn, oPeClr, oVecReady, oValid and oBusy are 0; oData = 0.
- oPeClr and oPeEn are registered state decodes: high during the CLR and RUN cycles respectively.
- iPeData is sampled in ACC, one cycle after the last oPeEn cycle, so the array's registered final count is used.
- Per vector pair: 1 IDLE + 1 CLR + STREAMLEN RUN + 1 ACC = STREAMLEN+3 cycles when iVecValid is already high. With defaults this is 131 cycles.
- oValid rises the cycle after the final ACC. oValid and oData hold stable until the iReady handshake.
- iReady with oValid high: the tile is transferred on that edge, and oValid is 0 on the next cycle.
  - A new iVecValid is accepted no earlier than the cycle after that, from IDLE.
- Asynchronous reset in any state, including mid-RUN, returns every register to its reset value immediately. The next operation starts from IDLE with kcnt = 0.

## Configuration
- OUTERPROD_ACC_SAT_EN defined:
  - Each accumulator update saturates to +(2^(ACCWIDTH-1)-1) or -2^(ACCWIDTH-1) on overflow.
  - The partial sum is computed at ACCWIDTH+1 bits before clamping.
- Undefined: accumulators wrap modulo 2^ACCWIDTH.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE, CLR, RUN, ACC, DONE);
  - the STREAMLEN derivation from BITWIDTH;
  - the default parameter values shared with the array.
- One sub-module, outerprod_acc_cell, instantiated once per entry. It holds one accumulator and performs sign-magnitude to two's complement conversion, add and optional saturation.
  - Inputs: clear, load strobe, OUTBITWIDTH product.
  - Output: ACCWIDTH value.

## Test plan
- Reset: hold iRstN low, then release. All outputs are 0 and state is IDLE. With iVecValid held low, oBusy stays 0 for 20 cycles.
- Accumulation, KDEPTH=2: every entry reads sign 0, magnitude 64 at both ACC cycles.
  - Response: oValid after 2×131 cycles, every oData entry = 128.
  - Response: oPeEn is high for exactly 128 cycles per pair, and oVecReady pulses twice.
- Sign handling, KDEPTH=2: entry 0 gives sign 1 mag 10, then sign 0 mag 3.
  - Response: entry 0 = -7 (0xFFF9 at ACCWIDTH 16).
  - Response: sign 1 mag 0 on entry 1 leaves it at 0.
- Overflow, ACCWIDTH=8, KDEPTH=2: magnitudes 100 then 100.
  - Response: 127 with OUTERPROD_ACC_SAT_EN, -56 without.
- Backpressure: hold iReady low for 5 cycles in DONE.
  - Response: oValid and oData are held; oPeEn, oPeClr and oVecReady stay 0; iVecValid is ignored.
  - Response: with iReady high, the tile transfers and the accumulators read 0 afterward.
- Reset mid-RUN: drop iRstN at RUN cycle 50.
  - Response: oPeEn is 0 immediately and all acc = 0.
  - Response: after release, a full KDEPTH sequence produces results identical to a clean run.
